// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the priority event encoder.
package prio_enc_pkg;

  localparam int unsigned PRIO_N_DEF = 8;
  // Widest vector the index helper scans; wider channel counts are not supported.
  localparam int unsigned PRIO_MAX_N = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } prio_state_e;

  // Highest set bit position of vec, or 0 when vec is all zeros.
  function automatic int unsigned prio_highest_idx(input logic [PRIO_MAX_N-1:0] vec);
    int unsigned hi;
    hi = 0;
    for (int unsigned i = 0; i < PRIO_MAX_N; i++) begin
      if (vec[i]) hi = i;
    end
    return hi;
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational N-to-W highest-index encoder with an any-set flag.
module prio_enc_comb
  import prio_enc_pkg::*;
#(
  parameter  int unsigned N = PRIO_N_DEF,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx_c,
  output logic         any_c
);

  assign any_c = |vec;
  assign idx_c = W'(prio_highest_idx(PRIO_MAX_N'(vec)));

endmodule

// File: rtl/prio_event_encoder.sv
// Registered N-channel event capture with highest-index-first valid/ready delivery.
// Optional sticky per-channel overflow flags are built when PRIO_ENC_OVF_EN is defined.
module prio_event_encoder
  import prio_enc_pkg::*;
#(
  parameter  int unsigned N = PRIO_N_DEF,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] ev,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
`ifdef PRIO_ENC_OVF_EN
  output logic [N-1:0] ovf,
  input  logic         ovf_clr,
`endif
  output logic [W-1:0] out_idx
);

  prio_state_e  state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] cap, clr_mask;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] hi_next;
  logic         valid_q, valid_d;
  logic         accept, any_next;

  assign accept = valid_q & out_ready;
  assign cap    = en ? ev : '0;

  // One-hot of the channel leaving this cycle.
  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask[idx_q] = 1'b1;
  end

  // A fresh event on the accepted channel re-sets its bit.
  assign pending_d = (pending_q & ~clr_mask) | cap;

  prio_enc_comb #(.N(N)) u_enc (
    .vec   (pending_d),
    .idx_c (hi_next),
    .any_c (any_next)
  );

  // Offered index is frozen until accepted, even if higher channels arrive.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_next) begin
          state_d = OFFER;
          idx_d   = hi_next;
        end
      end
      OFFER: begin
        if (accept) begin
          if (any_next) idx_d = hi_next;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == OFFER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign pending   = pending_q;

`ifdef PRIO_ENC_OVF_EN
  logic [N-1:0] ovf_q, ovf_set;

  // Event merged into a bit that is still pending and not leaving this cycle.
  assign ovf_set = cap & pending_q & ~clr_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= (ovf_clr ? '0 : ovf_q) | ovf_set;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_prio_event_encoder.sv
// Directed bench for prio_event_encoder with an expected-index scoreboard.
module tb_prio_event_encoder;

  localparam int unsigned N_CH = 8;
  localparam int unsigned W_CH = $clog2(N_CH);

  logic              clk;
  logic              rst;
  logic              en;
  logic [N_CH-1:0]   ev;
  logic              out_valid;
  logic              out_ready;
  logic [N_CH-1:0]   pending;
  logic [W_CH-1:0]   out_idx;
`ifdef PRIO_ENC_OVF_EN
  logic [N_CH-1:0]   ovf;
  logic              ovf_clr;
`endif

  int n_pass;
  int n_total;
  int exp_q[$];

  prio_event_encoder #(.N(N_CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ev        (ev),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
`ifdef PRIO_ENC_OVF_EN
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
`endif
    .out_idx   (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Accept every queued index back to back, checking order and valid each cycle.
  task automatic drain(input string tag);
    int e;
    out_ready = 1'b1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_idx"}, 32'(out_idx), 32'(e));
      step();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    en        = 1'b1;
    ev        = '0;
    out_ready = 1'b0;
`ifdef PRIO_ENC_OVF_EN
    ovf_clr   = 1'b0;
`endif
    repeat (3) step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_idx", 32'(out_idx), 32'd0);
      check("idle_pending", 32'(pending), 32'd0);
    end

    // Two events in one cycle, consumer ready
    out_ready = 1'b1;
    ev = 8'b0010_0100;
    step();
    ev = '0;
    check("two_pending", 32'(pending), 32'h24);
    exp_q.push_back(5);
    exp_q.push_back(2);
    drain("two");
    check("two_done_valid", 32'(out_valid), 32'd0);
    check("two_done_pending", 32'(pending), 32'd0);

    // Offered index held while stalled, despite higher-priority arrival
    ev = 8'h04;
    step();
    ev = 8'h80;
    step();
    ev = '0;
    check("hold_idx", 32'(out_idx), 32'd2);
    check("hold_pending", 32'(pending), 32'h84);
    repeat (3) step();
    check("hold_idx_late", 32'(out_idx), 32'd2);
    check("hold_valid_late", 32'(out_valid), 32'd1);
    exp_q.push_back(2);
    drain("hold_a");
    check("hold_cleared", 32'(pending), 32'h80);
    check("hold_next_idx", 32'(out_idx), 32'd7);
    exp_q.push_back(7);
    drain("hold_b");
    check("hold_done_valid", 32'(out_valid), 32'd0);

    // Accept and re-event on the same channel in one cycle
    ev = 8'h08;
    step();
    ev = '0;
    check("same_idx", 32'(out_idx), 32'd3);
    ev = 8'h08;
    out_ready = 1'b1;
    step();
    ev = '0;
    out_ready = 1'b0;
    check("same_pending", 32'(pending), 32'h08);
    check("same_valid", 32'(out_valid), 32'd1);
    check("same_reoffer", 32'(out_idx), 32'd3);
`ifdef PRIO_ENC_OVF_EN
    check("same_ovf", 32'(ovf), 32'd0);
`endif
    exp_q.push_back(3);
    drain("same");
    check("same_done_valid", 32'(out_valid), 32'd0);

    // Capture disabled
    en = 1'b0;
    ev = 8'hFF;
    step();
    step();
    ev = '0;
    en = 1'b1;
    check("en0_pending", 32'(pending), 32'd0);
    check("en0_valid", 32'(out_valid), 32'd0);

`ifdef PRIO_ENC_OVF_EN
    // Overflow set, sticky, clear, and set-beats-clear
    ev = 8'h02;
    step();
    check("ovf_first", 32'(ovf), 32'd0);
    step();
    ev = '0;
    check("ovf_set", 32'(ovf), 32'h02);
    step();
    check("ovf_sticky", 32'(ovf), 32'h02);
    ovf_clr = 1'b1;
    step();
    check("ovf_clr", 32'(ovf), 32'd0);
    ev = 8'h02;
    step();
    ev = '0;
    check("ovf_set_wins", 32'(ovf), 32'h02);
    step();
    ovf_clr = 1'b0;
    check("ovf_clr2", 32'(ovf), 32'd0);
    exp_q.push_back(1);
    drain("ovf");
    check("ovf_done_valid", 32'(out_valid), 32'd0);
`endif

    // All channels at once, delivered back to back
    out_ready = 1'b1;
    ev = 8'hFF;
    step();
    ev = '0;
    check("all_pending", 32'(pending), 32'hFF);
    for (int i = int'(N_CH) - 1; i >= 0; i--) exp_q.push_back(i);
    drain("all");
    check("all_done_valid", 32'(out_valid), 32'd0);
    check("all_done_pending", 32'(pending), 32'd0);

    // Asynchronous reset in the middle of an offer
    ev = 8'hF0;
    step();
    ev = '0;
    check("mid_pending", 32'(pending), 32'hF0);
    check("mid_idx", 32'(out_idx), 32'd7);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_pending", 32'(pending), 32'd0);
`ifdef PRIO_ENC_OVF_EN
    check("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
    #1;
    rst = 1'b0;
    step();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    ev = 8'h01;
    step();
    ev = '0;
    check("post_rst_pending", 32'(pending), 32'h01);
    exp_q.push_back(0);
    drain("post_rst");
    check("post_rst_done", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prio_event_encoder.md
# prio_event_encoder

Parametrised, registered N-channel priority encoder with event capture. A one-cycle event on any input line is latched into a per-channel pending bit. The highest-index pending channel is presented as an encoded index with a valid/ready handshake, and each accepted index clears its pending bit. It generalises the team's 3-input combinational priority encoder into the interrupt/event front end used by the lab controller designs.

## Interface
- N, 8, number of event channels (N >= 2)
- W, $clog2(N), index width (derived; not overridden)

Clocking and reset: one clock; reset is asynchronous and active-high.

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  capture enable; when low, ev is ignored
- ev  in  N  event lines, sampled every rising edge while en=1
- out_valid  out  1  out_idx holds a pending channel
- out_ready  in  1  consumer accepts out_idx this cycle
- out_idx  out  W  encoded channel number; highest index has priority
- pending  out  N  current pending register
- ovf  out  N  sticky per-channel overflow flags (PRIO_ENC_OVF_EN only)
- ovf_clr  in  1  clears all ovf bits (PRIO_ENC_OVF_EN only)

## Operation
- Reset values: pending=0, out_valid=0, out_idx=0, ovf=0.
- Accept: an edge where out_valid=1 and out_ready=1.
- pending_next[i] = (pending[i] & ~(accept & out_idx==i)) | (en & ev[i]).
- A new event on the channel being accepted wins, so the bit stays set.
- Output state machine, two states:
  - IDLE: out_valid=0. Moves to OFFER when pending_next is nonzero; out_idx is loaded with the highest set bit of pending_next.
  - OFFER: out_valid=1; out_idx is held while out_ready=0. This holds even if a higher-priority event arrives.
  - On accept in OFFER: reload out_idx from pending_next and stay in OFFER, or go to IDLE if pending_next is 0.
- No combinational path from ev or out_ready to any output; all outputs are registered.
- Events that hit an already-pending bit merge into it; no count is kept.
- ev with en=0 is dropped, but the handshake continues to drain pending.

## Timing
- Latency from an ev pulse in cycle k (sampled at edge k) to out_valid=1 and pending bit set: 1 edge, visible in cycle k+1.
- Back-to-back accepts: one index per cycle when out_ready is held high.
- The cleared bit is visible in pending in the cycle after the accept.
- Asserting rst mid-offer immediately drops out_valid and clears pending/ovf; pending events are lost.
- After rst deasserts, the first capture happens at the next rising edge.
- All N events in one cycle: indices N-1 down to 0 are delivered on N consecutive accepts.

## Configuration
- PRIO_ENC_OVF_EN defined: ovf[i] is set at any edge where en & ev[i] & pending[i] and channel i is not being accepted at that edge.
  - ovf is sticky until ovf_clr or rst.
  - ovf_clr and a new overflow in the same cycle: the set wins.
- PRIO_ENC_OVF_EN undefined: ovf and ovf_clr ports are absent; no overflow logic is generated.

## Structure
- Package prio_enc_pkg holds:
  - the default channel count constant PRIO_N_DEF=8;
  - the state typedef (IDLE, OFFER);
  - a function returning the highest set index of a vector, or 0 when the vector is zero.
- One sub-module, prio_enc_comb: purely combinational N-to-W highest-index encoder with an any-set output. It is instantiated on pending_next.

## Test plan
- Reset then no events -> out_valid=0, out_idx=0, pending=0 for 20 cycles.
- N=8; ev=8'b0010_0100 for one cycle, out_ready=1 -> out_idx=5 then 2 in consecutive cycles, then out_valid=0.
- Hold out_ready=0 while out_idx=2 is offered, then pulse ev[7] -> out_idx stays 2 until accepted; then 7 is offered.
- Accept idx 3 while ev[3]=1 in the same cycle -> pending[3] remains 1 and idx 3 is re-offered. With the macro, ovf[3] stays 0.
- With PRIO_ENC_OVF_EN: ev[1] twice while pending[1]=1 and unaccepted -> ovf=8'b0000_0010; ovf_clr clears it. Also en=0 with ev=8'hFF -> no change in pending.
- Assert rst mid-offer with pending=8'hF0 -> out_valid, pending and ovf read 0 in the same cycle, before the next edge.
